// File: rtl/mat_cache_loader_pkg.sv
// Shared types and constants for the matrix-cache write-side loader.
// Lane payloads are shortreal values carried as their raw IEEE-754 bit patterns.
package mat_cache_loader_pkg;

  localparam int DEFAULT_WIDTH      = 128;
  localparam int DEFAULT_CACHE_SIZE = 4;
  localparam int WORD_BITS          = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    XPOSE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Highest legal diagonal index of a WIDTH x WIDTH block.
  function automatic int max_diag(input int width);
    return 2 * width - 2;
  endfunction

endpackage

// File: rtl/mat_cache_loader_if.sv
// Command, vector-stream and cache-write signals of the loader.
// Each stream transfers on a rising edge where its valid and ready are both high.
// Valid is never conditioned on ready.
interface mat_cache_loader_if
  import mat_cache_loader_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int CACHE_SIZE      = DEFAULT_CACHE_SIZE,
  parameter int DIAG_SIZE       = 1 + $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
);

  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [CACHE_ADDR_SIZE-1:0]            cmd_addr;
  logic [DIAG_SIZE-1:0]                  cmd_first_diag;
  logic [DIAG_SIZE:0]                    cmd_count;
  logic                                  cmd_transpose;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [WIDTH-1:0][WORD_BITS-1:0]       in_data;

  logic                                  write_enable;
  logic [CACHE_ADDR_SIZE-1:0]            write_addr;
  logic [DIAG_SIZE-1:0]                  write_diag;
  logic [WIDTH-1:0][WORD_BITS-1:0]       write_data;
  logic                                  transpose_enable;
  logic [CACHE_ADDR_SIZE-1:0]            transpose_addr;

  logic                                  busy;
  logic                                  done;

  modport master (
    output cmd_valid, cmd_addr, cmd_first_diag, cmd_count, cmd_transpose,
    output in_valid, in_data,
    input  cmd_ready, in_ready,
    input  write_enable, write_addr, write_diag, write_data,
    input  transpose_enable, transpose_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_first_diag, cmd_count, cmd_transpose,
    input  in_valid, in_data,
    output cmd_ready, in_ready,
    output write_enable, write_addr, write_diag, write_data,
    output transpose_enable, transpose_addr, busy, done
  );

endinterface

// File: rtl/mat_cache_loader_diag_counter.sv
// Diagonal index counter: loads a start diagonal (out-of-range starts become 0)
// and advances by one per enable, wrapping from MAX_DIAG back to 0.
module mat_cache_loader_diag_counter #(
  parameter int DIAG_SIZE = 8,
  parameter int MAX_DIAG  = 254
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIAG_SIZE-1:0] load_value,
  input  logic                 enable,
  output logic [DIAG_SIZE-1:0] diag
);

  localparam logic [DIAG_SIZE-1:0] MAX = DIAG_SIZE'(MAX_DIAG);

  always_ff @(posedge clock) begin
    if (reset) begin
      diag <= '0;
    end else if (load) begin
      diag <= (load_value > MAX) ? '0 : load_value;
    end else if (enable) begin
      diag <= (diag == MAX) ? '0 : diag + DIAG_SIZE'(1);
    end
  end

endmodule

// File: rtl/mat_cache_loader.sv
// Write-side sequencer for the matrix cache: one command loads count vectors onto
// consecutive diagonals of a block, optionally transposes it, then pulses done.
module mat_cache_loader
  import mat_cache_loader_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int CACHE_SIZE      = DEFAULT_CACHE_SIZE,
  parameter int DIAG_SIZE       = 1 + $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  mat_cache_loader_if.slave bus,
  output loader_state_t     state_dbg
);

  localparam int CNT_SIZE = DIAG_SIZE + 1;

  loader_state_t                   state;
  loader_state_t                   state_next;
  logic [CACHE_ADDR_SIZE-1:0]      addr_q;
  logic [CNT_SIZE-1:0]             remaining_q;
  logic                            transpose_q;
  logic [DIAG_SIZE-1:0]            diag;

  logic                            write_enable_q;
  logic [CACHE_ADDR_SIZE-1:0]      write_addr_q;
  logic [DIAG_SIZE-1:0]            write_diag_q;
  logic [WIDTH-1:0][WORD_BITS-1:0] write_data_q;

  logic cmd_ready;
  logic in_ready;
  logic transpose_enable;
  logic done;
  logic cmd_fire;
  logic in_fire;

  assign cmd_fire = bus.cmd_valid && cmd_ready;
  assign in_fire  = bus.in_valid && in_ready;

  mat_cache_loader_diag_counter #(
    .DIAG_SIZE (DIAG_SIZE),
    .MAX_DIAG  (max_diag(WIDTH))
  ) u_diag_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cmd_fire),
    .load_value (bus.cmd_first_diag),
    .enable     (in_fire),
    .diag       (diag)
  );

  // XPOSE and DONE hold off their strobe while the last registered write is
  // still on the cache port, so transpose/done always follow the final write.
  always_comb begin
    state_next       = state;
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    transpose_enable = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_count != '0)   state_next = LOAD;
          else if (bus.cmd_transpose) state_next = XPOSE;
          else                        state_next = DONE;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid && remaining_q == CNT_SIZE'(1)) begin
          state_next = transpose_q ? XPOSE : DONE;
        end
      end
      XPOSE: begin
        if (!write_enable_q) begin
          transpose_enable = 1'b1;
          state_next       = DONE;
        end
      end
      DONE: begin
        if (!write_enable_q) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      transpose_q    <= 1'b0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_diag_q   <= '0;
      write_data_q   <= '0;
    end else begin
      state          <= state_next;
      write_enable_q <= in_fire;
      if (cmd_fire) begin
        addr_q      <= bus.cmd_addr;
        remaining_q <= bus.cmd_count;
        transpose_q <= bus.cmd_transpose;
      end
      if (in_fire) begin
        remaining_q  <= remaining_q - CNT_SIZE'(1);
        write_addr_q <= addr_q;
        write_diag_q <= diag;
        write_data_q <= bus.in_data;
      end
    end
  end

  assign bus.cmd_ready        = cmd_ready;
  assign bus.in_ready         = in_ready;
  assign bus.write_enable     = write_enable_q;
  assign bus.write_addr       = write_addr_q;
  assign bus.write_diag       = write_diag_q;
  assign bus.write_data       = write_data_q;
  assign bus.transpose_enable = transpose_enable;
  assign bus.transpose_addr   = addr_q;
  assign bus.busy             = (state != IDLE);
  assign bus.done             = done;
  assign state_dbg            = state;

endmodule

// File: tb/tb_mat_cache_loader.sv
// Self-checking bench for mat_cache_loader at WIDTH=4, CACHE_SIZE=4 (diagonals 0..6).
module tb_mat_cache_loader;
  import mat_cache_loader_pkg::*;

  localparam int WIDTH = 4;
  localparam int CACHE_SIZE = 4;
  localparam int MAXD = 6;
  localparam int NDIAG = 7;
  localparam int W = 2 + 3 + 128;

  typedef struct {
    int addr; int first; int count; int xp;
    int n_wr; int last_diag; int done_ofs; int xp_ofs;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  loader_state_t state_dbg;

  mat_cache_loader_if #(.WIDTH(WIDTH), .CACHE_SIZE(CACHE_SIZE)) bus();

  mat_cache_loader #(.WIDTH(WIDTH), .CACHE_SIZE(CACHE_SIZE)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int we_cnt = 0, xp_cnt = 0, done_cnt = 0;
  int last_we_cyc = 0, last_we_diag = 0, xp_cyc = 0, done_cyc = 0;
  logic hs_prev = 1'b0;
  logic done_prev = 1'b0;

  logic [W-1:0] exp_q[$];
  int xp_q[$];
  logic [127:0] ref_cache[4][8];
  logic [127:0] mdl_cache[4][8];
  bit ref_xp[4];
  bit mdl_xp[4];

  int cur_addr = 0, cur_first = 0, cur_idx = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor / scoreboard: builds the cache image from the write/transpose strobes.
  always @(negedge clock) begin
    logic [W-1:0] e;
    ncyc++;
    check("write_enable_timing", bus.write_enable, hs_prev);
    if (bus.write_enable) begin
      we_cnt++;
      last_we_cyc = ncyc;
      last_we_diag = int'(bus.write_diag);
      mdl_cache[bus.write_addr][bus.write_diag] = bus.write_data;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("write_record", {bus.write_addr, bus.write_diag, bus.write_data}, e);
      end
    end
    if (bus.transpose_enable) begin
      xp_cnt++;
      xp_cyc = ncyc;
      mdl_xp[bus.transpose_addr] ^= 1'b1;
      check("xpose_with_write", bus.write_enable, 1'b0);
      if (xp_q.size() == 0) check("unexpected_xpose", 1'b1, 1'b0);
      else check("xpose_addr", bus.transpose_addr, W'(xp_q.pop_front()));
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = ncyc;
      check("done_single_pulse", done_prev, 1'b0);
    end
    done_prev = bus.done;
    hs_prev = bus.in_valid && bus.in_ready && !reset;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cmd(input int addr, input int first, input int count, input int xp,
                           output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    bus.cmd_addr = 2'(addr);
    bus.cmd_first_diag = 3'(first);
    bus.cmd_count = 4'(count);
    bus.cmd_transpose = xp[0];
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = bus.cmd_ready;
      if (ok) acc = ncyc;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      timeout("cmd_accept");
    end else begin
      cur_addr = addr;
      cur_first = (first > MAXD) ? 0 : first;
      cur_idx = 0;
      if (xp != 0) begin
        ref_xp[addr] ^= 1'b1;
        xp_q.push_back(addr);
      end
    end
  endtask

  task automatic send_vec(input int gap);
    logic [127:0] d;
    bit ok;
    int dg;
    ok = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      timeout("vec_accept");
    end else begin
      dg = (cur_first + cur_idx) % NDIAG;
      exp_q.push_back({2'(cur_addr), 3'(dg), d});
      ref_cache[cur_addr][dg] = d;
      cur_idx++;
    end
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      #1;
      found = bus.done;
      tick();
    end
    if (!found) timeout("done_wait");
  endtask

  task automatic run_entry(input vec_t e, input string tag);
    int acc, we0, xp0, dn0;
    we0 = we_cnt;
    xp0 = xp_cnt;
    dn0 = done_cnt;
    drive_cmd(e.addr, e.first, e.count, e.xp, acc);
    for (int i = 0; i < e.count; i++) send_vec(0);
    wait_done();
    check({tag, "_writes"}, W'(we_cnt - we0), W'(e.n_wr));
    check({tag, "_done_count"}, W'(done_cnt - dn0), W'(1));
    check({tag, "_done_ofs"}, W'(done_cyc - acc), W'(e.done_ofs));
    check({tag, "_xpose_count"}, W'(xp_cnt - xp0), W'(e.xp));
    if (e.xp_ofs >= 0) check({tag, "_xpose_ofs"}, W'(xp_cyc - acc), W'(e.xp_ofs));
    if (e.n_wr > 0) check({tag, "_last_diag"}, W'(last_we_diag), W'(e.last_diag));
    @(negedge clock);
    #1;
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1'b1);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int acc1, acc2, acc, dn0;
    for (int a = 0; a < 4; a++) begin
      ref_xp[a] = 1'b0;
      mdl_xp[a] = 1'b0;
      for (int d = 0; d < 8; d++) begin
        ref_cache[a][d] = '0;
        mdl_cache[a][d] = '0;
      end
    end
    // {addr, first, count, xp, writes, last_diag, done_ofs, xpose_ofs}
    tbl[0] = '{2, 0, 7, 0, 7, 6, 9, -1};
    tbl[1] = '{1, 5, 4, 0, 4, 1, 6, -1};
    tbl[2] = '{0, 7, 3, 1, 3, 2, 6, 5};
    tbl[3] = '{3, 2, 0, 1, 0, 0, 2, 1};
    tbl[4] = '{1, 3, 0, 0, 0, 0, 1, -1};
    tbl[5] = '{0, 6, 1, 1, 1, 6, 4, 3};
    tbl[6] = '{3, 6, 7, 1, 7, 5, 10, 9};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_first_diag = '0;
    bus.cmd_count = '0;
    bus.cmd_transpose = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) tick();
    reset = 1'b0;

    @(negedge clock);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_write_enable", bus.write_enable, 1'b0);
    check("rst_transpose_enable", bus.transpose_enable, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_write_addr", bus.write_addr, '0);
    check("rst_write_diag", bus.write_diag, '0);
    check("rst_write_data", bus.write_data, '0);
    check("rst_transpose_addr", bus.transpose_addr, '0);
    check("rst_state", state_dbg, IDLE);
    tick();

    foreach (tbl[i]) run_entry(tbl[i], $sformatf("tbl%0d", i));

    // Gapped input stream followed by transpose.
    drive_cmd(3, 1, 2, 1, acc);
    send_vec(0);
    send_vec(1);
    wait_done();
    check("gap_xpose_after_write", W'(xp_cyc - last_we_cyc), W'(1));
    check("gap_xpose_ofs", W'(xp_cyc - acc), W'(5));
    check("gap_done_ofs", W'(done_cyc - acc), W'(6));
    check("gap_last_diag", W'(last_we_diag), W'(2));
    tick();

    // Reset in the middle of a load, with a vector being offered.
    drive_cmd(0, 0, 5, 0, acc);
    send_vec(0);
    send_vec(0);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    #1;
    check("mrst_write_enable", bus.write_enable, 1'b0);
    check("mrst_transpose_enable", bus.transpose_enable, 1'b0);
    check("mrst_done", bus.done, 1'b0);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_cmd_ready", bus.cmd_ready, 1'b1);
    check("mrst_in_ready", bus.in_ready, 1'b0);
    check("mrst_write_data", bus.write_data, '0);
    tick();
    run_entry('{1, 2, 3, 0, 3, 4, 5, -1}, "post_rst");

    // Vectors offered while idle, then a command held during a load.
    bus.in_valid = 1'b1;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("idle_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    drive_cmd(2, 3, 2, 0, acc1);
    bus.cmd_addr = 2'd0;
    bus.cmd_first_diag = 3'd0;
    bus.cmd_count = 4'd1;
    bus.cmd_transpose = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    #1;
    check("held_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    send_vec(0);
    send_vec(0);
    drive_cmd(0, 0, 1, 0, acc2);
    check("held_first_done_ofs", W'(done_cyc - acc1), W'(5));
    check("held_accept_after_done", W'(acc2 - done_cyc), W'(1));
    send_vec(0);
    wait_done();
    tick();

    // Randomized commands with random input gaps.
    for (int n = 0; n < 25; n++) begin
      int ra, rf, rc, rx;
      ra = $urandom_range(0, 3);
      rf = $urandom_range(0, 7);
      rc = $urandom_range(0, 7);
      rx = $urandom_range(0, 1);
      dn0 = done_cnt;
      drive_cmd(ra, rf, rc, rx, acc);
      for (int i = 0; i < rc; i++) send_vec($urandom_range(0, 2));
      wait_done();
      check("rand_done_count", W'(done_cnt - dn0), W'(1));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("exp_q_drained", W'(exp_q.size()), W'(0));
    check("xp_q_drained", W'(xp_q.size()), W'(0));
    for (int a = 0; a < 4; a++) begin
      check($sformatf("cache_xpose_flag_%0d", a), mdl_xp[a], ref_xp[a]);
      for (int d = 0; d < NDIAG; d++) begin
        check($sformatf("cache_%0d_%0d", a, d), mdl_cache[a][d], ref_cache[a][d]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
